// File: rtl/i4_mode_select_if.sv
// i4_mode_select_if: candidate prediction handshake between the intra-4x4 predictors and the mode selector.
// With I4_MODE_COST_EN defined the bundle also carries an 8-bit per-candidate side cost.
`timescale 1ns/1ps
interface i4_mode_select_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int MODE_W     = 4
);
    logic                                       pred_valid;
    logic                                       pred_ready;
    logic [MODE_W-1:0]                          pred_mode;
    logic                                       pred_last;
    logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred;
`ifdef I4_MODE_COST_EN
    logic [7:0]                                 pred_cost;

    modport master (output pred_valid, pred_mode, pred_last, pred, pred_cost, input pred_ready);
    modport slave  (input pred_valid, pred_mode, pred_last, pred, pred_cost, output pred_ready);
`else
    modport master (output pred_valid, pred_mode, pred_last, pred, input pred_ready);
    modport slave  (input pred_valid, pred_mode, pred_last, pred, output pred_ready);
`endif
endinterface

// File: rtl/i4_mode_select.sv
// i4_mode_select: scores 4x4 intra candidates by SSE against a latched source block and keeps the cheapest.
// Define I4_MODE_COST_EN to add the candidate's 8-bit pred_cost to each score.
`timescale 1ns/1ps
module i4_mode_select #(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 4,
    parameter int MODE_W     = 4,
    parameter int SCORE_W    = 20
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] src,
    i4_mode_select_if.slave                            pif,
    output logic                                       busy,
    output logic                                       done,
    output logic [MODE_W-1:0]                          best_mode,
    output logic [SCORE_W-1:0]                         best_score,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] best_pred
);
    localparam int NPIX  = BLOCK_SIZE * BLOCK_SIZE;
    localparam int BLK_W = BIT_WIDTH * NPIX;
    localparam int SQ_W  = 2 * BIT_WIDTH;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEPT = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]           state;
    logic [BLK_W-1:0]     src_q;
    logic [SCORE_W-1:0]   run_min;
    logic                 accept;

    logic [BIT_WIDTH-1:0] mag [NPIX];
    logic [SQ_W-1:0]      sq  [NPIX];

    logic                 s1_valid;
    logic [SQ_W-1:0]      s1_sq [NPIX];
    logic [MODE_W-1:0]    s1_mode;
    logic [BLK_W-1:0]     s1_pred;
`ifdef I4_MODE_COST_EN
    logic [7:0]           s1_cost;
`endif
    logic [SCORE_W-1:0]   score;

    assign pif.pred_ready = (state == ACCEPT);
    assign accept         = pif.pred_valid && pif.pred_ready;

    // |src - pred| squared equals the square of the signed difference and needs no sign handling
    always_comb begin
        for (int k = 0; k < NPIX; k++) begin
            if (src_q[k*BIT_WIDTH +: BIT_WIDTH] >= pif.pred[k*BIT_WIDTH +: BIT_WIDTH])
                mag[k] = src_q[k*BIT_WIDTH +: BIT_WIDTH] - pif.pred[k*BIT_WIDTH +: BIT_WIDTH];
            else
                mag[k] = pif.pred[k*BIT_WIDTH +: BIT_WIDTH] - src_q[k*BIT_WIDTH +: BIT_WIDTH];
            sq[k] = {{BIT_WIDTH{1'b0}}, mag[k]} * {{BIT_WIDTH{1'b0}}, mag[k]};
        end
    end

    always_comb begin
        score = '0;
        for (int k = 0; k < NPIX; k++)
            score = score + SCORE_W'(s1_sq[k]);
`ifdef I4_MODE_COST_EN
        score = score + SCORE_W'(s1_cost);
`endif
    end

    // Search control; DRAIN waits for the last candidate to leave stage 1 before signalling done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            src_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q <= src;
                        busy  <= 1'b1;
                        state <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (accept && pif.pred_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!s1_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strict less-than keeps the earlier mode on ties; the all-ones minimum lets the first candidate win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sq      <= '{default: '0};
            s1_mode    <= '0;
            s1_pred    <= '0;
`ifdef I4_MODE_COST_EN
            s1_cost    <= '0;
`endif
            run_min    <= '0;
            best_mode  <= '0;
            best_score <= '0;
            best_pred  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sq   <= sq;
                s1_mode <= pif.pred_mode;
                s1_pred <= pif.pred;
`ifdef I4_MODE_COST_EN
                s1_cost <= pif.pred_cost;
`endif
            end
            if (state == IDLE && start) begin
                run_min <= '1;
            end else if (s1_valid && score < run_min) begin
                run_min    <= score;
                best_mode  <= s1_mode;
                best_score <= score;
                best_pred  <= s1_pred;
            end
        end
    end
endmodule

// File: tb/tb_i4_mode_select.sv
// tb_i4_mode_select: randomized and directed searches checked against a plain arithmetic SSE model.
// Build with +define+I4_MODE_COST_EN to exercise the per-candidate cost path as well.
`timescale 1ns/1ps
module tb_i4_mode_select;
    localparam int BW   = 8;
    localparam int BS   = 4;
    localparam int MW   = 4;
    localparam int SW   = 20;
    localparam int NPIX = BS * BS;
    localparam int PW   = BW * NPIX;
    localparam int MAXC = 10;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] src   = '0;
    logic          busy;
    logic          done;
    logic [MW-1:0] best_mode;
    logic [SW-1:0] best_score;
    logic [PW-1:0] best_pred;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] t_src;
    logic [MW-1:0] c_mode [MAXC];
    logic [PW-1:0] c_pred [MAXC];
    logic [7:0]    c_cost [MAXC];

    i4_mode_select_if #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .MODE_W(MW)) pif ();

    i4_mode_select #(.BIT_WIDTH(BW), .BLOCK_SIZE(BS), .MODE_W(MW), .SCORE_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src        (src),
        .pif        (pif),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_score (best_score),
        .best_pred  (best_pred)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] fill(input logic [7:0] v);
        return {NPIX{v}};
    endfunction

    function automatic longint sse(input logic [PW-1:0] s, input logic [PW-1:0] p);
        longint acc;
        int d;
        acc = 0;
        for (int k = 0; k < NPIX; k++) begin
            d   = int'(s[k*8 +: 8]) - int'(p[k*8 +: 8]);
            acc = acc + longint'(d * d);
        end
        return acc;
    endfunction

    // First candidate is always taken, later ones only if strictly cheaper
    task automatic modelBest(input int n, output logic [MW-1:0] m, output longint sc, output logic [PW-1:0] p);
        longint c;
        m  = '0;
        sc = 0;
        p  = '0;
        for (int i = 0; i < n; i++) begin
            c = sse(t_src, c_pred[i]);
`ifdef I4_MODE_COST_EN
            c = c + longint'(c_cost[i]);
`endif
            if (i == 0 || c < sc) begin
                sc = c;
                m  = c_mode[i];
                p  = c_pred[i];
            end
        end
    endtask

    task automatic startSearch();
        pif.pred_valid = 1'b0;
        start = 1'b1;
        src   = t_src;
        @(posedge clk); #1;
        start = 1'b0;
        src   = ~t_src;
    endtask

    task automatic sendCand(input int i, input bit last, input bit gaps);
        bit acc;
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                pif.pred_valid = 1'b0;
                pif.pred       = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        pif.pred_valid = 1'b1;
        pif.pred_mode  = c_mode[i];
        pif.pred       = c_pred[i];
        pif.pred_last  = last;
`ifdef I4_MODE_COST_EN
        pif.pred_cost  = c_cost[i];
`endif
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            acc = pif.pred_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no pred_ready, expected acceptance of candidate %0d", i);
        end
        pif.pred_valid = 1'b0;
        pif.pred_last  = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input bit gaps, input bit glitch);
        logic [MW-1:0] em;
        longint        es;
        logic [PW-1:0] ep;
        int            lat;
        startSearch();
        if (glitch) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        checkOutput("busy_during", PW'(busy), PW'(1'b1));
        for (int i = 0; i < n; i++)
            sendCand(i, (i == n - 1), gaps);
        lat = 0;
        while (!done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("done_latency", PW'(lat), PW'(2));
        checkOutput("busy_at_done", PW'(busy), PW'(1'b0));
        modelBest(n, em, es, ep);
        checkOutput("best_mode", PW'(best_mode), PW'(em));
        checkOutput("best_score", PW'(best_score), PW'(es));
        checkOutput("best_pred", best_pred, ep);
        @(posedge clk); #1;
        checkOutput("done_one_cycle", PW'(done), PW'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("best_score_hold", PW'(best_score), PW'(es));
    endtask

    task automatic randomCands(input int n);
        for (int i = 0; i < n; i++) begin
            c_mode[i] = MW'(i);
            c_cost[i] = 8'($urandom_range(0, 255));
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                c_pred[i] = c_pred[i-1];
                c_cost[i] = c_cost[i-1];
            end else begin
                for (int k = 0; k < NPIX; k++)
                    c_pred[i][k*8 +: 8] = 8'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        int n;
        int done_seen;
        pif.pred_valid = 1'b0;
        pif.pred_mode  = '0;
        pif.pred_last  = 1'b0;
        pif.pred       = '0;
`ifdef I4_MODE_COST_EN
        pif.pred_cost  = '0;
`endif
        for (int i = 0; i < MAXC; i++) c_cost[i] = 8'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pred_ready", PW'(pif.pred_ready), PW'(1'b0));
        checkOutput("rst_busy", PW'(busy), PW'(1'b0));
        checkOutput("rst_done", PW'(done), PW'(1'b0));
        checkOutput("rst_best_mode", PW'(best_mode), PW'(0));
        checkOutput("rst_best_score", PW'(best_score), PW'(0));
        checkOutput("rst_best_pred", best_pred, PW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed: exact match wins");
        t_src = fill(8'h80);
        c_mode[0] = 4'd0; c_pred[0] = fill(8'h81);
        c_mode[1] = 4'd1; c_pred[1] = fill(8'h80);
        c_mode[2] = 4'd2; c_pred[2] = fill(8'h7E);
        applyStimulus(3, 1'b0, 1'b0);
        checkOutput("t1_mode", PW'(best_mode), PW'(1));
        checkOutput("t1_score", PW'(best_score), PW'(0));

        $display("[TB] directed: single candidate, maximum SSE");
        t_src = fill(8'h00);
        c_mode[0] = 4'd7; c_pred[0] = fill(8'hFF);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("t2_mode", PW'(best_mode), PW'(7));
        checkOutput("t2_score", PW'(best_score), PW'(1040400));

        $display("[TB] directed: tie keeps earlier mode");
        t_src = fill(8'h10);
        c_mode[0] = 4'd3; c_pred[0] = fill(8'h11);
        c_mode[1] = 4'd5; c_pred[1] = fill(8'h0F);
        applyStimulus(2, 1'b0, 1'b0);
        checkOutput("t3_mode", PW'(best_mode), PW'(3));
        checkOutput("t3_score", PW'(best_score), PW'(16));

        $display("[TB] idle: pred_valid without start");
        pif.pred_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("idle_ready", PW'(pif.pred_ready), PW'(1'b0));
        end
        pif.pred_valid = 1'b0;

        $display("[TB] random: gapped search with ignored restart, then back-to-back");
        for (int k = 0; k < NPIX; k++) t_src[k*8 +: 8] = 8'($urandom_range(0, 255));
        randomCands(MAXC);
        applyStimulus(MAXC, 1'b1, 1'b1);
        applyStimulus(MAXC, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, MAXC);
            for (int k = 0; k < NPIX; k++) t_src[k*8 +: 8] = 8'($urandom_range(0, 255));
            randomCands(n);
            applyStimulus(n, r[0], 1'b0);
        end

        $display("[TB] reset in the middle of a search");
        t_src = fill(8'h40);
        randomCands(4);
        startSearch();
        sendCand(0, 1'b0, 1'b0);
        sendCand(1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ready", PW'(pif.pred_ready), PW'(1'b0));
        checkOutput("mid_rst_busy", PW'(busy), PW'(1'b0));
        checkOutput("mid_rst_done", PW'(done), PW'(1'b0));
        checkOutput("mid_rst_mode", PW'(best_mode), PW'(0));
        checkOutput("mid_rst_score", PW'(best_score), PW'(0));
        checkOutput("mid_rst_pred", best_pred, PW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        checkOutput("mid_rst_no_done", PW'(done_seen), PW'(0));
        applyStimulus(4, 1'b0, 1'b0);

`ifdef I4_MODE_COST_EN
        $display("[TB] cost: side cost outweighs a perfect match");
        t_src = fill(8'h80);
        c_mode[0] = 4'd0; c_pred[0] = fill(8'h81); c_cost[0] = 8'd0;
        c_mode[1] = 4'd1; c_pred[1] = fill(8'h80); c_cost[1] = 8'd20;
        applyStimulus(2, 1'b0, 1'b0);
        checkOutput("t6_mode", PW'(best_mode), PW'(0));
        checkOutput("t6_score", PW'(best_score), PW'(16));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i4_mode_select.md
Name: i4_mode_select

Overview:
- Downstream consumer of the 4x4 intra predictors (TM4 and sibling DC/VE/HE/... blocks) in the intra-4x4 encode path.
- Accepts one candidate 4x4 prediction per handshake and scores it against the latched source block by sum of squared errors (SSE).
- Tracks the lowest-cost mode and reports best mode, score and predicted block to the residual/transform stage.

Parameters:
- BIT_WIDTH, 8, pixel width.
- BLOCK_SIZE, 4, block edge; block holds BLOCK_SIZE*BLOCK_SIZE pixels.
- MODE_W, 4, mode index width (10 intra-4x4 modes).
- SCORE_W, 20, score width; must be at least 2*BIT_WIDTH + log2(BLOCK_SIZE*BLOCK_SIZE).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; latches src and opens a new search
- src  in  BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE  source block, pixel (j,i) at index j*BLOCK_SIZE+i
- pred_valid  in  1  candidate valid
- pred_ready  out  1  candidate accepted when pred_valid && pred_ready
- pred_mode  in  MODE_W  candidate mode index
- pred_last  in  1  marks final candidate of the search
- pred  in  BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE  candidate block, same packing as src
- busy  out  1  search in progress
- done  out  1  one-cycle pulse; results valid
- best_mode  out  MODE_W  winning mode
- best_score  out  SCORE_W  winning cost
- best_pred  out  BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE  winning prediction block

Behaviour:
- Reset: pred_ready=0, busy=0, done=0, best_mode=0, best_score=0, best_pred=0; FSM enters IDLE; pipeline valids cleared.
- FSM states:
  - IDLE: start -> ACCEPT. Latch src, set the internal running minimum to all-ones, busy=1.
  - ACCEPT: pred_ready=1. An accepted beat with pred_last=1 -> DRAIN, and pred_ready drops the next cycle.
  - DRAIN: pred_ready=0. Wait until the pipeline is empty, pulse done for 1 cycle, busy=0 -> IDLE.
- start outside IDLE is ignored.
- Pipeline, acceptance at edge E0:
  - Stage 1 (registered at E0): 16 per-pixel squares, each (src-pred)^2 computed on a signed BIT_WIDTH+1 difference, unsigned 2*BIT_WIDTH result; mode and pred carried alongside.
  - Stage 2 (registered at E1): adder-tree sum to SCORE_W, compare, conditional update of best_*.
  - Throughput: one candidate per cycle, no bubbles required.
- Compare rule: update when score < current best (strict). Ties keep the earlier-accepted mode. The first candidate of a search always wins against the all-ones initial minimum.
- done asserts in the cycle after the last candidate's stage-2 update. best_* are stable from that cycle until the next search's first update.
- best_* outputs update only during a search. Between searches they hold the previous result.
- pred_valid is not required to be continuous. Gaps simply delay acceptance; results are identical to back-to-back input.
- A search with a single candidate is legal: pred_last on the first beat.
- No overflow: max SSE 16*255^2 = 1040400 < 2^20.
- rst_n asserted mid-search: immediate return to reset values. No done pulse; the partial search is discarded.

Optional Feature:
- Macro I4_MODE_COST_EN.
- When defined:
  - Extra input port pred_cost, 8 bits, sampled with the candidate.
  - Cost = SSE + pred_cost, zero-extended; fits in SCORE_W without saturation.
  - best_score reports this total.
- When undefined: port absent; cost = SSE only.

Test Plan:
1. src all 0x80. Candidates mode0 all 0x81, mode1 all 0x80, mode2 all 0x7E (last) -> best_mode=1, best_score=0, best_pred all 0x80, done 2 cycles after last accept.
2. src all 0x00, single candidate mode 7 all 0xFF with pred_last -> best_mode=7, best_score=1040400, done pulses once.
3. Tie: src all 0x10. mode3 all 0x11, then mode5 all 0x0F (last) -> both score 16; best_mode=3.
4. pred_valid high with no start -> pred_ready stays 0. start ignored while busy. Random pred_valid gaps over 10 candidates -> result equal to the back-to-back run.
5. rst_n low for 1 cycle after 2 of 4 candidates -> all outputs 0, busy=0, no done. A new start then completes normally.
6. I4_MODE_COST_EN: src all 0x80. mode0 all 0x81 with cost 0, mode1 all 0x80 with cost 20 -> best_mode=0, best_score=16.
